// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the datapath and stall/flush controls back to it.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_memRead;
    logic [4:0]       ex_writeReg;
    logic             mem_branch;
    logic             mem_zf;
    logic             mem_jump;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             pipe_hold;
    logic             pc_redirect;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memRead, ex_writeReg,
               mem_branch, mem_zf, mem_jump, dmem_req, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
               pipe_hold, pc_redirect, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memRead, ex_writeReg,
               mem_branch, mem_zf, mem_jump, dmem_req, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
               pipe_hold, pc_redirect, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline (load-use, MEM redirect,
// data-memory waits with timeout halt) plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t           state;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             halted_q;
    logic             taken, load_use, mwait, hold, redirect, bubble;

    always_comb begin
        taken    = (bus.mem_branch & bus.mem_zf) | bus.mem_jump;
        load_use = bus.ex_memRead & (bus.ex_writeReg != 5'd0) &
                   ((bus.ex_writeReg == bus.id_rs) | (bus.id_uses_rt & (bus.ex_writeReg == bus.id_rt)));
        mwait    = bus.dmem_req & ~bus.dmem_ready;
        // In MEM_WAIT only the ready strobe matters; the request is already latched in EX/MEM.
        hold     = (state == HALT) | ((state == RUN) & mwait) | ((state == MEM_WAIT) & ~bus.dmem_ready);
        redirect = ~hold & taken;
        bubble   = ~hold & ~taken & load_use;
    end

    assign bus.pc_write    = rst_n & ~hold & ~bubble;
    assign bus.ifid_write  = rst_n & ~hold & ~bubble;
    assign bus.ifid_flush  = ~rst_n | redirect;
    assign bus.idex_flush  = ~rst_n | redirect | bubble;
    assign bus.exmem_flush = ~rst_n | redirect;
    assign bus.pipe_hold   = rst_n & hold;
    assign bus.pc_redirect = rst_n & redirect;
    assign bus.halted      = halted_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            if (!bus.pc_write && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (redirect && flush_q != '1) flush_q <= flush_q + 1'b1;
            case (state)
                RUN: if (mwait) begin
                    state    <= MEM_WAIT;
                    wait_cnt <= WW'(1);
                end
                MEM_WAIT: if (bus.dmem_ready) begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end else if (wait_cnt == TMO) begin
                    state    <= HALT;
                    halted_q <= 1'b1;
                end else wait_cnt <= wait_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vector table for single-cycle decisions plus hand sequences
// for memory waits, timeout halt, counter saturation and asynchronous reset.
module tb_pipeline_hazard_ctrl;
    localparam logic [7:0] ADV = 8'b1100_0000;
    localparam logic [7:0] LU  = 8'b0001_0000;
    localparam logic [7:0] TKN = 8'b1111_1010;
    localparam logic [7:0] WT  = 8'b0000_0100;
    localparam logic [7:0] HLT = 8'b0000_0101;
    localparam logic [7:0] RST = 8'b0011_1000;

    // ctl bits: {id_uses_rt, ex_memRead, mem_branch, mem_zf, mem_jump, dmem_req, dmem_ready}
    typedef struct packed {
        logic [4:0] rs, rt, wr;
        logic [6:0] ctl;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n = 0;
    int   bad = 0;
    vec_t v[12];
    logic [7:0] outs;

    pipeline_hazard_ctrl_if #(.CNT_W(4)) b ();
    pipeline_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

    always #5 clk = ~clk;

    assign outs = {b.pc_write, b.ifid_write, b.ifid_flush, b.idex_flush,
                   b.exmem_flush, b.pipe_hold, b.pc_redirect, b.halted};

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        b.id_rs = x.rs;
        b.id_rt = x.rt;
        b.ex_writeReg = x.wr;
        {b.id_uses_rt, b.ex_memRead, b.mem_branch, b.mem_zf, b.mem_jump, b.dmem_req, b.dmem_ready} = x.ctl;
    endtask

    task automatic ctl(input logic [6:0] c);
        drive({5'd0, 5'd0, 5'd0, c, 8'd0});
    endtask

    task automatic step(input string nm, input logic [7:0] exp);
        @(negedge clk);
        check(nm, {24'd0, outs}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input string nm);
        #2 rst_n = 1'b0;
        #1;
        check({nm, "_outs"}, {24'd0, outs}, {24'd0, RST});
        check({nm, "_stall"}, {28'd0, b.stall_cnt}, 32'd0);
        check({nm, "_flush"}, {28'd0, b.flush_cnt}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        v[0]  = {5'd0, 5'd0, 5'd0, 7'b0000000, ADV};
        v[1]  = {5'd8, 5'd0, 5'd8, 7'b0100000, LU};
        v[2]  = {5'd0, 5'd0, 5'd0, 7'b1100000, ADV};
        v[3]  = {5'd3, 5'd8, 5'd8, 7'b0100000, ADV};
        v[4]  = {5'd3, 5'd8, 5'd8, 7'b1100000, LU};
        v[5]  = {5'd8, 5'd8, 5'd8, 7'b1000000, ADV};
        v[6]  = {5'd8, 5'd0, 5'd8, 7'b0111000, TKN};
        v[7]  = {5'd8, 5'd0, 5'd8, 7'b0010000, ADV};
        v[8]  = {5'd0, 5'd0, 5'd0, 7'b0000100, TKN};
        v[9]  = {5'd0, 5'd0, 5'd0, 7'b0000011, ADV};
        v[10] = {5'd5, 5'd9, 5'd9, 7'b1110000, LU};
        v[11] = {5'd0, 5'd0, 5'd0, 7'b0011011, TKN};
        ctl(7'b0);
        pulse_reset("rst0");

        for (int i = 0; i < 12; i++) begin
            drive(v[i]);
            step($sformatf("vec%0d", i), v[i].exp);
        end
        check("table_stall", {28'd0, b.stall_cnt}, 32'd3);
        check("table_flush", {28'd0, b.flush_cnt}, 32'd3);

        // three-cycle memory wait, then ready
        pulse_reset("rst4");
        ctl(7'b0000010);
        step("w_run", WT);
        step("w_mw1", WT);
        step("w_mw2", WT);
        ctl(7'b0000011);
        step("w_ready", ADV);
        check("w_stall", {28'd0, b.stall_cnt}, 32'd3);
        ctl(7'b0000010);
        step("wj_run", WT);
        ctl(7'b0000111);
        step("wj_jump", TKN);
        check("wj_flush", {28'd0, b.flush_cnt}, 32'd1);
        ctl(7'b0);
        step("wj_back", ADV);

        // timeout: one RUN wait cycle plus four MEM_WAIT cycles, then HALT
        pulse_reset("rst5");
        ctl(7'b0000010);
        for (int i = 0; i < 5; i++) step($sformatf("to_wait%0d", i), WT);
        step("halt0", HLT);
        ctl(7'b0000111);
        step("halt1", HLT);
        step("halt2", HLT);
        check("halt_stall", {28'd0, b.stall_cnt}, 32'd8);
        pulse_reset("rst_halt");
        ctl(7'b0);
        step("after_halt", ADV);

        // counter saturation
        pulse_reset("rst6");
        drive({5'd8, 5'd0, 5'd8, 7'b0100000, 8'd0});
        for (int i = 0; i < 20; i++) step($sformatf("sat_lu%0d", i), LU);
        check("sat_stall", {28'd0, b.stall_cnt}, 32'd15);
        ctl(7'b0000100);
        for (int i = 0; i < 20; i++) step($sformatf("sat_j%0d", i), TKN);
        check("sat_flush", {28'd0, b.flush_cnt}, 32'd15);

        // reset mid-wait must clear state and wait count
        ctl(7'b0000010);
        step("mid_run", WT);
        step("mid_mw1", WT);
        pulse_reset("rst_mid");
        ctl(7'b0000000);
        step("mid_after", ADV);
        ctl(7'b0000010);
        for (int i = 0; i < 5; i++) step($sformatf("mid_wait%0d", i), WT);
        step("mid_halt", HLT);

        $display("== %0d vectors applied, %0d miscompares ==", n, bad);
        $finish;
    end
endmodule
